// File: rtl/touch_scan_sequencer.sv
// Touch scan sequencer: drives N oversampled conversions through the touch SPI master,
// averages each channel and publishes all channels together with a one-cycle strobe.
module touch_scan_sequencer #(
  parameter int          CLK_FREQ_MHZ = 1,
  parameter int          NUM_CH       = 2,
  parameter logic [31:0] CH_CMDS      = 32'h0F0D0B09,
  parameter int          OVERSAMPLE   = 4,
  parameter int          DATA_W       = 12,
  parameter int          SETTLE_US    = 50,
  parameter int          TIMEOUT_US   = 150000,
  parameter int          HOLDOFF_US   = 150000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     t_irq,
  input  logic                     spi_busy,
  input  logic                     spi_valid,
  input  logic [15:0]              spi_data,
  output logic                     spi_en,
  output logic [7:0]               spi_cmd,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     new_data,
  output logic                     timeout_err,
  output logic                     pen_down,
  output logic                     scanning
);

  localparam int SHIFT = $clog2(OVERSAMPLE);
  localparam int ACC_W = DATA_W + SHIFT;
  localparam int N_W   = (OVERSAMPLE > 1) ? SHIFT : 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [N_W-1:0]  N_LAST      = N_W'(OVERSAMPLE - 1);
  localparam logic [CH_W-1:0] CH_LAST     = CH_W'(NUM_CH - 1);
  localparam logic [23:0]     SETTLE_CYC  = 24'(SETTLE_US * CLK_FREQ_MHZ);
  localparam logic [23:0]     TIMEOUT_CYC = 24'(TIMEOUT_US * CLK_FREQ_MHZ);
  localparam logic [23:0]     HOLDOFF_CYC = 24'(HOLDOFF_US * CLK_FREQ_MHZ);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_SETTLE  = 3'd3,
    S_PUBLISH = 3'd4,
    S_HOLDOFF = 3'd5
  } state_t;

  state_t                     r_state, w_next;
  logic [1:0]                 r_sync;
  logic [23:0]                r_timer, w_timer_val;
  logic                       w_timer_load;
  logic [ACC_W-1:0]           r_acc, w_sum;
  logic [N_W-1:0]             r_n;
  logic [CH_W-1:0]            r_ch;
  logic [NUM_CH*DATA_W-1:0]   r_staging, r_ch_data;
  logic                       r_new_data;
  logic [DATA_W-1:0]          w_sample;
  logic                       w_last_n, w_last_ch, w_timer_done;

  // Idle level of the synchroniser is pen-up, so pen_down reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], t_irq};
  end

  assign pen_down     = ~r_sync[1];
  assign w_sample     = spi_data[15 -: DATA_W];
  assign w_sum        = r_acc + ACC_W'(w_sample);
  assign w_last_n     = (r_n == N_LAST);
  assign w_last_ch    = (r_ch == CH_LAST);
  assign w_timer_done = (r_timer <= 24'd1);

  generate
    if (DATA_W < 16) begin : g_unused
      logic w_unused_lsbs;
      assign w_unused_lsbs = ^spi_data[15-DATA_W:0];
    end
  endgenerate

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_next       = r_state;
    w_timer_load = 1'b0;
    w_timer_val  = '0;
    spi_en       = 1'b0;
    spi_cmd      = '0;
    timeout_err  = 1'b0;
    case (r_state)
      S_IDLE:    if (pen_down && !spi_busy) w_next = S_ISSUE;
      S_ISSUE: begin
        spi_cmd = CH_CMDS[8*int'(r_ch) +: 8];
        if (!spi_busy) begin
          spi_en       = 1'b1;
          w_timer_load = 1'b1;
          w_timer_val  = TIMEOUT_CYC;
          w_next       = S_WAIT;
        end
      end
      S_WAIT: begin
        // pen_down is deliberately ignored here: PENIRQ glitches while converting.
        if (spi_valid) begin
          if (w_last_n && w_last_ch) begin
            w_next = S_PUBLISH;
          end else begin
            w_next       = S_SETTLE;
            w_timer_load = 1'b1;
            w_timer_val  = SETTLE_CYC;
          end
        end else if (w_timer_done) begin
          timeout_err  = 1'b1;
          w_next       = S_HOLDOFF;
          w_timer_load = 1'b1;
          w_timer_val  = HOLDOFF_CYC;
        end
      end
      S_SETTLE: begin
        if (!pen_down)                    w_next = S_IDLE;
        else if (w_timer_done && !spi_busy) w_next = S_ISSUE;
      end
      S_PUBLISH: begin
        w_next       = S_HOLDOFF;
        w_timer_load = 1'b1;
        w_timer_val  = HOLDOFF_CYC;
      end
      S_HOLDOFF: if (w_timer_done) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_acc      <= '0;
      r_n        <= '0;
      r_ch       <= '0;
      // NOTE: the staging bank is reset too, so an aborted scan can never leak into ch_data.
      r_staging  <= '0;
      r_ch_data  <= '0;
      r_new_data <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_new_data <= (r_state == S_PUBLISH);
      if (w_timer_load)       r_timer <= w_timer_val;
      else if (r_timer != '0) r_timer <= r_timer - 24'd1;

      case (r_state)
        S_IDLE: begin
          r_acc <= '0;
          r_n   <= '0;
          r_ch  <= '0;
        end
        S_WAIT: begin
          if (spi_valid) begin
            if (w_last_n) begin
              r_staging[DATA_W*int'(r_ch) +: DATA_W] <= DATA_W'(w_sum >> SHIFT);
              r_acc <= '0;
              r_n   <= '0;
              r_ch  <= r_ch + CH_W'(1);
            end else begin
              r_acc <= w_sum;
              r_n   <= r_n + N_W'(1);
            end
          end else if (w_timer_done) begin
            r_staging <= '0;
          end
        end
        S_PUBLISH: r_ch_data <= r_staging;
        default: ;
      endcase
    end
  end

  // new_data is registered so it rises on the same edge that loads ch_data.
  assign ch_data  = r_ch_data;
  assign new_data = r_new_data;
  assign scanning = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_SETTLE);

endmodule

// File: tb/tb_touch_scan_sequencer.sv
// Self-checking bench for touch_scan_sequencer: SPI responder, event monitor and
// an averaging reference model computed directly from the returned words.
module tb_touch_scan_sequencer;
  localparam int NCH = 4, OS = 4, DW = 12, SET = 5, TMO = 10, HLD = 20, LAT = 3;

  logic clk = 1'b0, rst = 1'b1, t_irq = 1'b1;
  logic spi_busy = 1'b0, spi_valid = 1'b0;
  logic [15:0] spi_data = '0;
  logic spi_en, new_data, timeout_err, pen_down, scanning;
  logic [7:0] spi_cmd;
  logic [NCH*DW-1:0] ch_data;

  always #5 clk = ~clk;

  touch_scan_sequencer #(
    .CLK_FREQ_MHZ(1), .NUM_CH(NCH), .CH_CMDS(32'h0F0D0B09), .OVERSAMPLE(OS),
    .DATA_W(DW), .SETTLE_US(SET), .TIMEOUT_US(TMO), .HOLDOFF_US(HLD)
  ) dut (
    .clk(clk), .rst(rst), .t_irq(t_irq), .spi_busy(spi_busy), .spi_valid(spi_valid),
    .spi_data(spi_data), .spi_en(spi_en), .spi_cmd(spi_cmd), .ch_data(ch_data),
    .new_data(new_data), .timeout_err(timeout_err), .pen_down(pen_down), .scanning(scanning)
  );

  int total = 0, bad = 0, cyc = 0;
  logic spi_mute = 1'b0;
  logic [15:0] rsp_q[$];
  int en_cyc[$], nd_cyc[$], te_cyc[$];
  logic [7:0] cmd_q[$];
  logic [47:0] nd_dat[$];
  int vld_cnt = 0, viol_edge = 0, viol_busy = 0, viol_dbl = 0;
  logic m_prev_en = 1'b0, m_prev_rst = 1'b1, m_en = 1'b0;
  logic [47:0] m_prev_ch = '0;
  int m_cnt = 0;

  // Monitor samples at negedge; responder drives SPI inputs just after posedge.
  always begin
    @(negedge clk);
    cyc++;
    m_en = spi_en;
    if (spi_en) begin
      en_cyc.push_back(cyc);
      cmd_q.push_back(spi_cmd);
      if (spi_busy) viol_busy++;
      if (m_prev_en) viol_dbl++;
    end
    if (new_data) begin
      nd_cyc.push_back(cyc);
      nd_dat.push_back(ch_data);
    end
    if (timeout_err) te_cyc.push_back(cyc);
    if (spi_valid) vld_cnt++;
    if (ch_data !== m_prev_ch && !new_data && !m_prev_rst) viol_edge++;
    m_prev_ch  = ch_data;
    m_prev_en  = spi_en;
    m_prev_rst = rst;
    @(posedge clk);
    #1;
    spi_valid = 1'b0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        spi_valid = 1'b1;
        spi_busy  = 1'b0;
        spi_data  = (rsp_q.size() > 0) ? rsp_q.pop_front() : 16'h0000;
      end
    end
    if (m_en && !spi_mute) begin
      spi_busy = 1'b1;
      m_cnt    = LAT;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int cnt(input int kind);
    case (kind)
      0:       return en_cyc.size();
      1:       return nd_cyc.size();
      2:       return te_cyc.size();
      default: return vld_cnt;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int kind, input int target, input int budget);
    int n = 0;
    while (cnt(kind) < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 64'(cnt(kind) >= target), 64'd1);
  endtask

  // Average of each channel's OS raw samples, truncated.
  function automatic logic [47:0] model(input logic [15:0] w[16]);
    logic [47:0] r = '0;
    for (int c = 0; c < NCH; c++) begin
      int sum = 0;
      for (int j = 0; j < OS; j++) sum += int'(w[c*OS+j][15:4]);
      r[c*DW +: DW] = 12'(sum / OS);
    end
    return r;
  endfunction

  function automatic logic [7:0] ecmd(input int i);
    logic [7:0] cmds[4] = '{8'h09, 8'h0B, 8'h0D, 8'h0F};
    return cmds[(i % 16) / OS];
  endfunction

  task automatic fill(output logic [15:0] w[16]);
    for (int i = 0; i < 16; i++) w[i] = 16'($urandom);
  endtask

  task automatic push(input logic [15:0] w[16]);
    for (int i = 0; i < 16; i++) rsp_q.push_back(w[i]);
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_spi_en"},   64'(spi_en), 64'd0);
    check({pfx, "_spi_cmd"},  64'(spi_cmd), 64'd0);
    check({pfx, "_ch_data"},  64'(ch_data), 64'd0);
    check({pfx, "_new_data"}, 64'(new_data), 64'd0);
    check({pfx, "_timeout"},  64'(timeout_err), 64'd0);
    check({pfx, "_pen_down"}, 64'(pen_down), 64'd0);
    check({pfx, "_scanning"}, 64'(scanning), 64'd0);
  endtask

  logic [15:0] wa[16], wb[16], wc[16], wd[16], we[16], wf[16];
  logic [47:0] exp_b, exp_d;
  int eb, tb0;

  initial begin
    rst = 1'b1;
    t_irq = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check_idle_outputs("rst");
    step();
    rst = 1'b0;

    // Two back-to-back scans; scan B holds the truncation case on channel 0.
    fill(wa);
    fill(wb);
    wb[0] = 16'(100 << 4);
    wb[1] = 16'(101 << 4);
    wb[2] = 16'(102 << 4);
    wb[3] = 16'(104 << 4);
    push(wa);
    push(wb);
    exp_b = model(wb);
    t_irq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pen_lat_1", 64'(pen_down), 64'd0);
    @(negedge clk);
    check("pen_lat_2", 64'(pen_down), 64'd1);
    wait_for("scan_ab_nd", 1, 2, 1500);
    check("scan_ab_en_cnt", 64'(en_cyc.size()), 64'd32);
    for (int i = 0; i < 32; i++)
      check($sformatf("scan_ab_cmd%0d", i), 64'((i < cmd_q.size()) ? cmd_q[i] : 8'hxx), 64'(ecmd(i)));
    check("scan_a_data", 64'(nd_dat.size() > 0 ? nd_dat[0] : 48'hx), 64'(model(wa)));
    check("scan_b_data", 64'(nd_dat.size() > 1 ? nd_dat[1] : 48'hx), 64'(exp_b));
    check("scan_b_trunc_ch0", 64'(nd_dat.size() > 1 ? nd_dat[1][11:0] : 12'hx), 64'd101);
    check("holdoff_after_pub", 64'((en_cyc.size() > 16 && nd_cyc.size() > 0) ? en_cyc[16] - nd_cyc[0] : -1),
          64'(HLD + 1));
    step();
    t_irq = 1'b1;
    repeat (40) @(negedge clk);
    check("idle_after_release", 64'(scanning), 64'd0);
    check("no_extra_scan", 64'(en_cyc.size()), 64'd32);

    // Pen release during SETTLE after the second X sample.
    fill(wc);
    push(wc);
    eb = en_cyc.size();
    tb0 = vld_cnt;
    t_irq = 1'b0;
    wait_for("abort_vld2", 3, tb0 + 2, 300);
    step();
    t_irq = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_en_cnt", 64'(en_cyc.size() - eb), 64'd2);
    check("abort_no_nd", 64'(nd_cyc.size()), 64'd2);
    check("abort_no_te", 64'(te_cyc.size()), 64'd0);
    check("abort_ch_data", 64'(ch_data), 64'(exp_b));
    check("abort_idle", 64'(scanning), 64'd0);

    // Fresh press restarts at channel 0, sample 0, with a clean accumulator.
    rsp_q.delete();
    fill(wd);
    push(wd);
    exp_d = model(wd);
    eb = en_cyc.size();
    t_irq = 1'b0;
    wait_for("fresh_nd", 1, 3, 1000);
    check("fresh_first_cmd", 64'(cmd_q.size() > eb ? cmd_q[eb] : 8'hxx), 64'h09);
    check("fresh_en_cnt", 64'(en_cyc.size() - eb), 64'd16);
    check("fresh_data", 64'(nd_dat.size() > 2 ? nd_dat[2] : 48'hx), 64'(exp_d));
    step();
    t_irq = 1'b1;
    repeat (40) @(negedge clk);

    // Timeout: responder never returns a result.
    spi_mute = 1'b1;
    eb = en_cyc.size();
    tb0 = te_cyc.size();
    t_irq = 1'b0;
    wait_for("to_first", 2, tb0 + 1, 200);
    check("to_latency", 64'((te_cyc.size() > tb0 && en_cyc.size() > eb) ? te_cyc[tb0] - en_cyc[eb] : -1),
          64'(TMO));
    wait_for("to_reissue", 0, eb + 2, 100);
    check("to_holdoff", 64'((en_cyc.size() > eb + 1 && te_cyc.size() > tb0) ? en_cyc[eb+1] - te_cyc[tb0] : -1),
          64'(HLD + 2));
    step();
    t_irq = 1'b1;
    wait_for("to_second", 2, tb0 + 2, 100);
    check("to_latency2", 64'((te_cyc.size() > tb0 + 1 && en_cyc.size() > eb + 1) ? te_cyc[tb0+1] - en_cyc[eb+1] : -1),
          64'(TMO));
    check("to_no_nd", 64'(nd_cyc.size()), 64'd3);
    check("to_ch_data", 64'(ch_data), 64'(exp_d));
    repeat (40) @(negedge clk);
    check("to_idle", 64'(scanning), 64'd0);
    spi_mute = 1'b0;

    // Reset during WAIT; the in-flight result later lands while IDLE.
    rsp_q.delete();
    fill(we);
    push(we);
    eb = en_cyc.size();
    t_irq = 1'b0;
    wait_for("rst_mid_issue", 0, eb + 6, 500);
    step();
    rst = 1'b1;
    t_irq = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    repeat (20) @(negedge clk);
    check("rst_valid_ignored", 64'(en_cyc.size() - eb), 64'd6);
    check("rst_idle", 64'(scanning), 64'd0);
    rsp_q.delete();
    fill(wf);
    push(wf);
    eb = en_cyc.size();
    t_irq = 1'b0;
    wait_for("post_rst_nd", 1, 4, 1000);
    check("post_rst_first_cmd", 64'(cmd_q.size() > eb ? cmd_q[eb] : 8'hxx), 64'h09);
    check("post_rst_data", 64'(nd_dat.size() > 3 ? nd_dat[3] : 48'hx), 64'(model(wf)));
    step();
    t_irq = 1'b1;
    repeat (30) @(negedge clk);

    check("same_edge_publish", 64'(viol_edge), 64'd0);
    check("en_while_busy", 64'(viol_busy), 64'd0);
    check("en_back_to_back", 64'(viol_dbl), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
